lcm_from_gcd: RTL and testbench

Sequential least-common-multiple stage that sits directly downstream of the 16-bit subtractive GCD unit. It consumes that unit's 16-bit result and level READY together with the original operands X and Y. It computes LCM = (X / G) * Y with a 16-step restoring divider followed by a 16-step shift-add multiplier, and presents a 32-bit result with its own READY.

---
 rtl/lcm_from_gcd_if.sv | 23 ++
 rtl/lcm_from_gcd.sv | 158 +++++++++++++++
 tb/tb_lcm_from_gcd.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/lcm_from_gcd_if.sv
// Handshake bundle between the upstream GCD unit, the LCM stage and its consumer.
// Operands X/Y, GCD result G with its level READY in; LCM result, READY and ERR out.
interface lcm_from_gcd_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0]   X;
  logic [WIDTH-1:0]   Y;
  logic [WIDTH-1:0]   G;
  logic               G_READY;
  logic [2*WIDTH-1:0] OUT;
  logic               READY;
  logic               ERR;

  modport master (
    output X, Y, G, G_READY,
    input  OUT, READY, ERR
  );

  modport slave (
    input  X, Y, G, G_READY,
    output OUT, READY, ERR
  );
endinterface

// File: rtl/lcm_from_gcd.sv
// LCM = (X / G) * Y via a WIDTH-step restoring divider then a WIDTH-step shift-add multiplier.
// Optional LCM_REM_CHECK_EN: flag ERR when G does not divide X (non-zero remainder).
module lcm_from_gcd #(
  parameter int unsigned WIDTH = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  lcm_from_gcd_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [WIDTH-1:0]   g_q, g_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] out_q, out_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;

  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_sub;
  logic               rem_ge;
  logic [WIDTH-1:0]   quo_step;
  logic [2*WIDTH-1:0] acc_step;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      g_q      <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      out_q    <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      g_q      <= g_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    g_d      = g_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    out_d    = out_q;
    ready_d  = ready_q;
    err_d    = err_q;

    // The partial remainder stays below G, so the borrow out of the
    // (WIDTH+1)-bit subtraction is exactly the "rem < G" decision.
    rem_shift = {rem_q, x_q[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, g_q};
    rem_ge    = ~rem_sub[WIDTH];
    // Dividend bits leave x_q at the MSB while quotient bits enter at the LSB,
    // so after WIDTH steps x_q holds the quotient.
    quo_step  = {x_q[WIDTH-2:0], rem_ge};
    acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    case (state_q)
      IDLE: begin
        if (bus.G_READY) begin
          if (bus.G != '0) begin
            x_d     = bus.X;
            y_d     = bus.Y;
            g_d     = bus.G;
            rem_d   = '0;
            cnt_d   = CNT_W'(WIDTH);
            state_d = DIV;
          end else begin
            out_d   = '0;
            err_d   = 1'b1;
            ready_d = 1'b1;
            state_d = DONE;
          end
        end
      end

      DIV: begin
        rem_d = rem_ge ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        x_d   = quo_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          mcand_d  = {{WIDTH{1'b0}}, quo_step};
          mplier_d = y_q;
          acc_d    = '0;
          cnt_d    = CNT_W'(WIDTH);
          state_d  = MUL;
        end
      end

      MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          out_d   = acc_step;
          ready_d = 1'b1;
`ifdef LCM_REM_CHECK_EN
          err_d   = (rem_q != '0);
`else
          err_d   = 1'b0;
`endif
          state_d = DONE;
        end
      end

      DONE: begin
        if (!bus.G_READY) begin
          ready_d = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.OUT   = out_q;
  assign bus.READY = ready_q;
  assign bus.ERR   = err_q;

endmodule

// File: tb/tb_lcm_from_gcd.sv
// Directed and random checks of lcm_from_gcd: result, error flag and fixed latency,
// with expected results queued at stimulus time and popped when READY rises.
module tb_lcm_from_gcd;
  localparam int unsigned W = 16;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;

  lcm_from_gcd_if #(.WIDTH(W)) bus ();

  lcm_from_gcd #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] out;
    logic        err;
    int unsigned lat;
    int unsigned cap;
  } exp_t;

  exp_t        sb[$];
  int unsigned tests    = 0;
  int unsigned fails    = 0;
  int unsigned edge_cnt = 0;

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] gcd(input logic [15:0] a_in, input logic [15:0] b_in);
    logic [15:0] a, b, t;
    a = a_in;
    b = b_in;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic start(input logic [15:0] x, input logic [15:0] y, input logic [15:0] g,
                       input logic [31:0] eo, input logic ee, input int unsigned el);
    exp_t e;
    @(negedge CLK);
    bus.X       = x;
    bus.Y       = y;
    bus.G       = g;
    bus.G_READY = 1'b1;
    e.out = eo;
    e.err = ee;
    e.lat = el;
    e.cap = edge_cnt + 1;
    sb.push_back(e);
  endtask

  task automatic wait_result(input string tag);
    exp_t        e;
    int unsigned n;
    n = 0;
    while (bus.READY !== 1'b1 && n < 200) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check({tag, "_ready"}, {31'd0, bus.READY}, 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_out"}, bus.OUT, e.out);
      check({tag, "_err"}, {31'd0, bus.ERR}, {31'd0, e.err});
      check({tag, "_lat"}, edge_cnt - e.cap + 1, e.lat);
    end
  endtask

  task automatic release_ready(input string tag, input logic [31:0] held);
    @(negedge CLK);
    bus.G_READY = 1'b0;
    @(posedge CLK);
    #1;
    check({tag, "_rdy_fall"}, {31'd0, bus.READY}, 32'd0);
    check({tag, "_err_fall"}, {31'd0, bus.ERR}, 32'd0);
    check({tag, "_out_hold"}, bus.OUT, held);
  endtask

  initial begin
    logic [15:0] rx, ry, rg;
    logic [31:0] rexp;
    exp_t        e;
    logic        rem_err;
`ifdef LCM_REM_CHECK_EN
    rem_err = 1'b1;
`else
    rem_err = 1'b0;
`endif

    bus.X       = '0;
    bus.Y       = '0;
    bus.G       = '0;
    bus.G_READY = 1'b0;
    #2 RESET = 1'b1;
    #1;
    check("rst_out", bus.OUT, 32'd0);
    check("rst_ready", {31'd0, bus.READY}, 32'd0);
    check("rst_err", {31'd0, bus.ERR}, 32'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;

    start(16'd123, 16'd456, 16'd3, 32'd18696, 1'b0, 33);
    wait_result("t123_456");
    release_ready("t123_456", 32'd18696);

    start(16'd456, 16'd123, 16'd3, 32'd18696, 1'b0, 33);
    wait_result("t456_123");
    release_ready("t456_123", 32'd18696);

    start(16'd456, 16'd456, 16'd456, 32'd456, 1'b0, 33);
    wait_result("t456_456");
    release_ready("t456_456", 32'd456);

    start(16'd65535, 16'd65534, 16'd1, 32'hFFFD0002, 1'b0, 33);
    wait_result("tmax");
    release_ready("tmax", 32'hFFFD0002);

    start(16'd0, 16'd0, 16'd0, 32'd0, 1'b1, 1);
    wait_result("tg0");
    release_ready("tg0", 32'd0);

    start(16'd10, 16'd4, 16'd3, 32'd12, rem_err, 33);
    wait_result("trem");
    release_ready("trem", 32'd12);

    // Operands change and G_READY drops mid-computation: no effect on the result.
    start(16'd456, 16'd123, 16'd3, 32'd18696, 1'b0, 33);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    bus.X       = 16'd1;
    bus.Y       = 16'd1;
    bus.G       = 16'd7;
    bus.G_READY = 1'b0;
    wait_result("tmid");
    @(posedge CLK);
    #1;
    check("tmid_rdy_fall", {31'd0, bus.READY}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      rx   = 16'($urandom_range(1, 65535));
      ry   = 16'($urandom_range(1, 65535));
      rg   = gcd(rx, ry);
      rexp = 32'(rx / rg) * 32'(ry);
      start(rx, ry, rg, rexp, 1'b0, 33);
      wait_result("trand");
      release_ready("trand", rexp);
    end

    // Reset mid-run clears the held nonzero OUT; a still-high G_READY restarts.
    start(16'd123, 16'd456, 16'd3, 32'd18696, 1'b0, 33);
    e = sb.pop_front();
    repeat (10) @(posedge CLK);
    #2 RESET = 1'b1;
    #1;
    check("tabort_out", bus.OUT, 32'd0);
    check("tabort_ready", {31'd0, bus.READY}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    e.cap = edge_cnt + 1;
    sb.push_back(e);
    wait_result("trestart");
    release_ready("trestart", 32'd18696);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
